// File: rtl/tone_sequencer_if.sv
// Valid/ready stream carrying the tone frequency from the sequencer to the wavetable.
interface Axis_If #(
  parameter int unsigned DATA_W = 24
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/tone_sequencer.sv
// Plays a programmed list of {frequency, duration} steps to a wavetable,
// with optional looping, abort and a closing silence transfer.
module tone_sequencer #(
  parameter int unsigned F_SAMPLE = 48_000,
  parameter int unsigned F_CLOCK  = 100_000_000,
  parameter int unsigned DEPTH    = 16,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  Axis_If.Master        freq,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_freq,
  input  logic [15:0]   wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  localparam int unsigned FW    = 24;
  localparam int unsigned DW    = 16;
  localparam int unsigned EW    = FW + DW;
  localparam int unsigned DIV   = F_CLOCK / F_SAMPLE;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [AW-1:0]    STEP_LAST = AW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_SILENCE = 3'd4;

  logic [EW-1:0]    prog_mem [DEPTH];
  logic [EW-1:0]    entry;
  logic [FW-1:0]    entry_freq;
  logic [DW-1:0]    entry_dur;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [FW-1:0]    freq_lat_q, freq_lat_d;
  logic [DW-1:0]    dur_lat_q, dur_lat_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DW-1:0]    smp_cnt_q, smp_cnt_d;
  logic             valid_q, valid_d;
  logic [FW-1:0]    data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_q;
  logic             hold_last;

  // Program store; writable at any time, playback works from latched copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        prog_mem[i] <= '0;
      end
    end else if (wr_en) begin
      prog_mem[wr_addr] <= {wr_freq, wr_dur};
    end
  end

  assign entry      = prog_mem[step_q];
  assign entry_freq = entry[EW-1:DW];
  assign entry_dur  = entry[DW-1:0];

  // Divider counts clocks per sample, sample counter counts sample periods.
  assign hold_last = (div_cnt_q == DIV_LAST) && (smp_cnt_q == (dur_lat_q - DW'(1)));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    freq_lat_d = freq_lat_q;
    dur_lat_d  = dur_lat_q;
    div_cnt_d  = div_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_LOAD;
          step_d  = '0;
        end
      end
      S_LOAD: begin
        if (stop || (entry_dur == '0)) begin
          state_d = S_SILENCE;
        end else begin
          freq_lat_d = entry_freq;
          dur_lat_d  = entry_dur;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (stop) begin
          state_d = S_SILENCE;
        end else if (freq.ready) begin
          state_d   = S_HOLD;
          div_cnt_d = '0;
          smp_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_SILENCE;
        end else if (hold_last) begin
          if (step_q != STEP_LAST) begin
            step_d  = step_q + AW'(1);
            state_d = S_LOAD;
          end else if (loop_en) begin
            step_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_SILENCE;
          end
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          smp_cnt_d = smp_cnt_q + DW'(1);
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_SILENCE: begin
        if (freq.ready) begin
          state_d = S_IDLE;
          step_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs follow the next state so they are registered with it.
    valid_d = (state_d == S_SEND) || (state_d == S_SILENCE);
    data_d  = (state_d == S_SEND) ? freq_lat_d : '0;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      freq_lat_q <= '0;
      dur_lat_q  <= '0;
      div_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      freq_lat_q <= freq_lat_d;
      dur_lat_q  <= dur_lat_d;
      div_cnt_q  <= div_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start;
    end
  end

  assign freq.valid = valid_q;
  assign freq.data  = data_q;
  assign busy       = busy_q;
  assign step_idx   = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at DIV=10, DEPTH=4.
module tb_tone_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam logic [23:0] F0    = 24'h037000;
  localparam logic [23:0] F1    = 24'h06E000;
  localparam logic [23:0] FNEW  = 24'h0AA000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_freq;
  logic [15:0]   wr_dur;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  int tests = 0;
  int fails = 0;

  Axis_If #(.DATA_W(24)) fbus ();

  tone_sequencer #(
    .F_SAMPLE(48_000),
    .F_CLOCK (480_000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .freq    (fbus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_freq (wr_freq),
    .wr_dur  (wr_dur),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .busy    (busy),
    .step_idx(step_idx),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Packed view: {3'b0, valid, data[23:0], busy, done, step_idx[1:0]}
  function automatic logic [31:0] pk(input logic v, input logic [23:0] d, input logic b,
                                     input logic dn, input logic [1:0] s);
    return {3'b000, v, d, b, dn, s};
  endfunction

  function automatic logic [23:0] sf(input int unsigned i);
    return 24'((i + 1) * 32'h1000);
  endfunction

  task automatic chk_all(input string tag, input logic v, input logic [23:0] d,
                         input logic b, input logic dn, input logic [1:0] s);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = pk(fbus.valid, fbus.data, busy, done, step_idx);
    exp = pk(v, d, b, dn, s);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {v,data,busy,done,step}=%08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] f, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_freq = f;
    wr_dur  = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Start pulse sampled at edge N; checks through the first SEND at N+2.
  task automatic play_start(input string tag, input logic [23:0] f);
    start = 1'b1;
    tick();
    chk_all({tag, "_edgeN"}, 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);
    start = 1'b0;
    tick();
    chk_all({tag, "_edgeN1"}, 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all({tag, "_send"}, 1'b1, f, 1'b1, 1'b0, 2'd0);
  endtask

  // From first HOLD cycle of a dur=3 step 0 followed by a dur=0 step 1.
  task automatic tail_to_done(input string tag);
    ticks(29);
    chk_all({tag, "_hold_last"}, 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all({tag, "_load1"}, 1'b0, 24'h0, 1'b1, 1'b0, 2'd1);
    tick();
    chk_all({tag, "_silence"}, 1'b1, 24'h0, 1'b1, 1'b0, 2'd1);
    tick();
    chk_all({tag, "_done"}, 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);
    tick();
    chk_all({tag, "_idle"}, 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_freq    = '0;
    wr_dur     = '0;
    start      = 1'b0;
    stop       = 1'b0;
    loop_en    = 1'b0;
    fbus.ready = 1'b1;
    ticks(2);
    chk_all("reset", 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b1;
    tick();

    // Basic two-step program: 440 Hz for 3 samples then end marker
    wr(2'd0, F0, 16'd3);
    wr(2'd1, F1, 16'd0);
    play_start("basic", F0);
    tick();
    chk_all("basic_hold0", 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tail_to_done("basic");

    // Backpressure during SEND
    fbus.ready = 1'b0;
    play_start("stall", F0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("stall_hold_bus", 1'b1, F0, 1'b1, 1'b0, 2'd0);
    end
    fbus.ready = 1'b1;
    tick();
    chk_all("stall_hold0", 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tail_to_done("stall");

    // Looping over all entries with dur=1 (12 cycles per step)
    for (int unsigned i = 0; i < DEPTH; i++) wr(AW'(i), sf(i), 16'd1);
    loop_en = 1'b1;
    play_start("loop", sf(0));
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      ticks(12);
      chk_all("loop_step", 1'b1, sf(k % DEPTH), 1'b1, 1'b0, AW'(k % DEPTH));
    end
    loop_en = 1'b0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      ticks(12);
      chk_all("loop_final_pass", 1'b1, sf(k), 1'b1, 1'b0, AW'(k));
    end
    ticks(11);
    chk_all("loop_silence", 1'b1, 24'h0, 1'b1, 1'b0, 2'd3);
    tick();
    chk_all("loop_done", 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);

    // Stop 4 cycles into HOLD; start during playback ignored; stop in SILENCE ignored
    wr(2'd0, F0, 16'd3);
    play_start("stop", F0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    chk_all("stop_hold4", 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    stop = 1'b1;
    tick();
    chk_all("stop_silence", 1'b1, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("stop_done", 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);
    stop = 1'b0;
    tick();
    chk_all("stop_idle", 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);

    // Stop during stalled SEND abandons the tone
    fbus.ready = 1'b0;
    play_start("stopsend", F0);
    stop = 1'b1;
    tick();
    chk_all("stopsend_silence", 1'b1, 24'h0, 1'b1, 1'b0, 2'd0);
    stop = 1'b0;
    fbus.ready = 1'b1;
    tick();
    chk_all("stopsend_done", 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);

    // Rewrite active entry during HOLD: current duration kept, new freq next pass
    loop_en = 1'b1;
    play_start("rewr", F0);
    tick();
    wr(2'd0, FNEW, 16'd1);
    ticks(28);
    chk_all("rewr_hold_last", 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("rewr_load1", 1'b0, 24'h0, 1'b1, 1'b0, 2'd1);
    tick();
    chk_all("rewr_send1", 1'b1, sf(1), 1'b1, 1'b0, 2'd1);
    ticks(12);
    chk_all("rewr_send2", 1'b1, sf(2), 1'b1, 1'b0, 2'd2);
    ticks(12);
    chk_all("rewr_send3", 1'b1, sf(3), 1'b1, 1'b0, 2'd3);
    ticks(12);
    chk_all("rewr_send0_new", 1'b1, FNEW, 1'b1, 1'b0, 2'd0);
    loop_en = 1'b0;
    stop = 1'b1;
    tick();
    chk_all("rewr_silence", 1'b1, 24'h0, 1'b1, 1'b0, 2'd0);
    stop = 1'b0;
    tick();
    chk_all("rewr_done", 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);

    // Reset during HOLD clears outputs at once and wipes the program
    play_start("rst", FNEW);
    ticks(2);
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_all("rst_after", 1'b0, 24'h0, 1'b0, 1'b0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_all("rst_load", 1'b0, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("rst_empty_silence", 1'b1, 24'h0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_all("rst_empty_done", 1'b0, 24'h0, 1'b0, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
